// File: rtl/fp_to_long_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_to_long_if
// Purpose  : Start/done handshake bundle for the double-to-long converter.
// Revision : 1.0
// ============================================================================
interface fp_to_long_if;
    logic [63:0] fp_in;
    logic        start;
    logic [63:0] long_out;
    logic        invalid;
    logic        done;
    logic        busy;

    modport master (
        output fp_in,
        output start,
        input  long_out,
        input  invalid,
        input  done,
        input  busy
    );

    modport slave (
        input  fp_in,
        input  start,
        output long_out,
        output invalid,
        output done,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/fp_to_long.sv
`default_nettype none
// ============================================================================
// Module   : fp_to_long
// Purpose  : IEEE-754 double to signed 64-bit integer, round toward zero,
//            using a one-bit-per-cycle aligner. Define FP_TO_LONG_SATURATE_EN
//            for sign-aware saturation and a zero NaN result.
// Revision : 1.0
// ============================================================================
module fp_to_long (
    input  wire logic   clk,
    input  wire logic   rst_n,
    fp_to_long_if.slave bus
);
    localparam logic [63:0] c_MIN_LONG = 64'h8000_0000_0000_0000;
    localparam logic [63:0] c_NEG_2P63 = 64'hC3E0_0000_0000_0000;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_UNPACK   = 3'd1,
        S_CLASSIFY = 3'd2,
        S_SHIFT    = 3'd3,
        S_SIGN     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t             r_state;
    logic [63:0]        r_op;
    logic [63:0]        r_mant;
    logic signed [11:0] r_exp;
    logic               r_sign;
    logic [63:0]        r_long;
    logic               r_invalid;
    logic               r_done;
    logic               r_busy;

    logic [63:0]        w_ovf;
    logic [63:0]        w_nan;

`ifdef FP_TO_LONG_SATURATE_EN
    localparam logic [63:0] c_MAX_LONG = 64'h7FFF_FFFF_FFFF_FFFF;
    assign w_ovf = r_sign ? c_MIN_LONG : c_MAX_LONG;
    assign w_nan = 64'd0;
`else
    assign w_ovf = c_MIN_LONG;
    assign w_nan = c_MIN_LONG;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_op      <= 64'd0;
            r_mant    <= 64'd0;
            r_exp     <= 12'sd0;
            r_sign    <= 1'b0;
            r_long    <= 64'd0;
            r_invalid <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op    <= bus.fp_in;
                        r_busy  <= 1'b1;
                        r_state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    r_exp   <= $signed({1'b0, r_op[62:52]}) - 12'sd1023;
                    r_mant  <= {1'b1, r_op[51:0], 11'b0};
                    r_sign  <= r_op[63];
                    r_state <= S_CLASSIFY;
                end
                S_CLASSIFY: begin
                    // Every branch except the normal range writes the result here.
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                    if (r_op[62:52] == 11'h7FF) begin
                        r_long    <= (r_op[51:0] != 52'd0) ? w_nan : w_ovf;
                        r_invalid <= 1'b1;
                    end else if (r_exp < 12'sd0) begin
                        r_long    <= 64'd0;
                        r_invalid <= 1'b0;
                    end else if (r_exp >= 12'sd63) begin
                        if (r_op == c_NEG_2P63) begin
                            r_long    <= c_MIN_LONG;
                            r_invalid <= 1'b0;
                        end else begin
                            r_long    <= w_ovf;
                            r_invalid <= 1'b1;
                        end
                    end else begin
                        r_state <= S_SHIFT;
                        r_done  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    // Shifting until e reaches 63 leaves the integer part in mant.
                    if (r_exp != 12'sd63) begin
                        r_mant <= r_mant >> 1;
                        r_exp  <= r_exp + 12'sd1;
                    end else begin
                        r_state <= S_SIGN;
                    end
                end
                S_SIGN: begin
                    r_long    <= r_sign ? (64'd0 - r_mant) : r_mant;
                    r_invalid <= 1'b0;
                    r_done    <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.long_out = r_long;
    assign bus.invalid  = r_invalid;
    assign bus.done     = r_done;
    assign bus.busy     = r_busy;

endmodule
`default_nettype wire
